// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit.
//
// Fetches one 32-bit instruction at a time from instruction memory, holds it in
// the instruction register (IR) until the consumer accepts it, then advances the
// PC (sequentially or to a branch target) and fetches again. A memory that fails
// to acknowledge within TIMEOUT request cycles drives the unit into a sticky
// fault state that only reset clears.
//
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   imem_req         - read request (high in FETCH/WAIT)
//   imem_addr        - read address (current PC)
//   imem_ack         - read data valid this cycle
//   imem_rdata       - instruction word from memory
//   Instr            - held instruction register
//   Cond/Op/Funct/Rd - IR fields [31:28], [27:26], [25:20], [15:12]
//   instr_valid      - IR holds an instruction not yet consumed
//   instr_ack        - consumer accept (transfer when instr_valid & instr_ack)
//   PCSrc            - branch taken, sampled on transfer
//   BranchTarget     - next PC when PCSrc=1, sampled on transfer
//   PCPlus4/PCPlus8  - PC of the instruction in IR plus 4 / plus 8
//   fetch_err        - sticky memory-timeout fault
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [3:0]  Cond,
    output logic [1:0]  Op,
    output logic [5:0]  Funct,
    output logic [3:0]  Rd,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic        PCSrc,
    input  logic [31:0] BranchTarget,
    output logic [31:0] PCPlus4,
    output logic [31:0] PCPlus8,
    output logic        fetch_err
);

    localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {FETCH, WAIT, ISSUE, FAULT} state_t;

    state_t           state;
    logic [31:0]      pc;
    logic [31:0]      ir;
    logic [31:0]      ir_pc;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_inc;
    logic             req_r;
    logic             valid_r;
    logic             err_r;

    assign wait_inc = wait_cnt + CNT_W'(1);

    // Outputs are registered alongside the state so they change only on clock edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            ir       <= '0;
            ir_pc    <= RESET_PC;
            wait_cnt <= '0;
            req_r    <= 1'b1;
            valid_r  <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            unique case (state)
                FETCH, WAIT: begin
                    if (imem_ack) begin
                        ir      <= imem_rdata;
                        ir_pc   <= pc;
                        state   <= ISSUE;
                        req_r   <= 1'b0;
                        valid_r <= 1'b1;
                    end else if (wait_inc == TIMEOUT_CNT) begin
                        // Fault on the cycle the count reaches the limit; no extra request.
                        wait_cnt <= wait_inc;
                        state    <= FAULT;
                        req_r    <= 1'b0;
                        err_r    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_inc;
                        state    <= WAIT;
                    end
                end
                ISSUE: begin
                    // Memory acks are ignored here; only the consumer moves us on.
                    if (instr_ack) begin
                        pc       <= PCSrc ? {BranchTarget[31:2], 2'b00} : pc + 32'd4;
                        wait_cnt <= '0;
                        state    <= FETCH;
                        req_r    <= 1'b1;
                        valid_r  <= 1'b0;
                    end
                end
                FAULT: begin
                    // Terminal until reset.
                end
                default: begin
                    state <= FAULT;
                end
            endcase
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = pc;
    assign instr_valid = valid_r;
    assign fetch_err   = err_r;

    assign Instr = ir;
    assign Cond  = ir[31:28];
    assign Op    = ir[27:26];
    assign Funct = ir[25:20];
    assign Rd    = ir[15:12];

    assign PCPlus4 = ir_pc + 32'd4;
    assign PCPlus8 = ir_pc + 32'd8;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit.
//
// A behavioural model (pending-instruction flag, fault flag, no-ack cycle count,
// PC and IR) is stepped on each rising edge from the inputs the DUT sampled; a
// compare process checks every DUT output against it on each falling edge.
// Directed sequences pin the model with literal expectations, then a long
// randomized run with random resets exercises the rest.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned TIMEOUT  = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic [3:0]  Cond;
    logic [1:0]  Op;
    logic [5:0]  Funct;
    logic [3:0]  Rd;
    logic        instr_valid;
    logic        instr_ack;
    logic        PCSrc;
    logic [31:0] BranchTarget;
    logic [31:0] PCPlus4;
    logic [31:0] PCPlus8;
    logic        fetch_err;

    instr_fetch_unit #(
        .RESET_PC(RESET_PC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .Instr       (Instr),
        .Cond        (Cond),
        .Op          (Op),
        .Funct       (Funct),
        .Rd          (Rd),
        .instr_valid (instr_valid),
        .instr_ack   (instr_ack),
        .PCSrc       (PCSrc),
        .BranchTarget(BranchTarget),
        .PCPlus4     (PCPlus4),
        .PCPlus8     (PCPlus8),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    // Behavioural model
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic [31:0] m_ir_pc;
    bit          m_have;   // an instruction is waiting for the consumer
    bit          m_fault;
    int          m_waits;  // consecutive request cycles without an ack

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_ir    = 32'h0;
        m_ir_pc = RESET_PC;
        m_have  = 1'b0;
        m_fault = 1'b0;
        m_waits = 0;
    endtask

    task automatic model_step();
        if (m_fault) return;
        if (m_have) begin
            if (instr_ack) begin
                m_pc    = PCSrc ? (BranchTarget & 32'hFFFF_FFFC) : m_pc + 32'd4;
                m_have  = 1'b0;
                m_waits = 0;
            end
        end else if (imem_ack) begin
            m_ir    = imem_rdata;
            m_ir_pc = m_pc;
            m_have  = 1'b1;
        end else begin
            m_waits++;
            if (m_waits >= int'(TIMEOUT)) m_fault = 1'b1;
        end
    endtask

    // Step the model with the inputs sampled at this edge, then drive the next cycle's inputs.
    task automatic tk(input bit r, input bit ack, input logic [31:0] rd, input bit ia,
                      input bit ps, input logic [31:0] bt);
        @(posedge clk);
        #1;
        if (!rst) model_step();
        rst          = r;
        imem_ack     = ack;
        imem_rdata   = rd;
        instr_ack    = ia;
        PCSrc        = ps;
        BranchTarget = bt;
        if (r) model_reset();
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            if (!rst) chk("imem_req", {31'b0, imem_req}, {31'b0, !m_have && !m_fault});
            if (!rst && !m_have && !m_fault) chk("imem_addr", imem_addr, m_pc);
            chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_have});
            chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_fault});
            chk("Instr", Instr, m_ir);
            chk("fields", {Cond, Op, Funct, Rd}, {16'b0, m_ir[31:26], m_ir[25:20], m_ir[15:12]});
            if (m_have) begin
                chk("PCPlus4", PCPlus4, m_ir_pc + 32'd4);
                chk("PCPlus8", PCPlus8, m_ir_pc + 32'd8);
            end
        end
    end

    initial begin
        int unsigned ack_pct;
        rst          = 1'b1;
        imem_ack     = 1'b0;
        imem_rdata   = 32'h0;
        instr_ack    = 1'b0;
        PCSrc        = 1'b0;
        BranchTarget = 32'h0;
        model_reset();
        cmp_en = 1'b1;

        // Reset state
        tk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_err", {31'b0, fetch_err}, 32'd0);
        chk("rst_instr", Instr, 32'h0);

        // Ack in the first FETCH cycle
        tk(1'b0, 1'b1, 32'hE080_2003, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("first_req", {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, RESET_PC);
        tk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("first_valid", {31'b0, instr_valid}, 32'd1);
        chk("first_cond", {28'b0, Cond}, 32'hE);
        chk("first_op", {30'b0, Op}, 32'h0);
        chk("first_funct", {26'b0, Funct}, 32'h08);
        chk("first_rd", {28'b0, Rd}, 32'h2);
        chk("first_pcplus8", PCPlus8, 32'h8);
        chk("issue_req", {31'b0, imem_req}, 32'd0);

        // Branch to 0x10, sequential to 0x14, branch to 0x203 -> 0x200
        tk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10);
        tk(1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("br_addr_10", imem_addr, 32'h10);
        tk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tk(1'b0, 1'b1, 32'h2222_2222, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("seq_addr_14", imem_addr, 32'h14);
        tk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h203);
        tk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("br_addr_200", imem_addr, 32'h200);

        // Consumer stalls 5 cycles while memory sends spurious acks
        tk(1'b0, 1'b1, 32'hA5A5_0F0F, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tk(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            chk("stall_instr", Instr, 32'hA5A5_0F0F);
            chk("stall_req", {31'b0, imem_req}, 32'd0);
            chk("stall_valid", {31'b0, instr_valid}, 32'd1);
        end
        tk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

        // Ack delayed by 3 cycles
        for (int i = 0; i < 4; i++) begin
            tk(1'b0, (i == 3), 32'h1234_5678, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            chk("wait_addr", imem_addr, 32'h204);
            chk("wait_valid", {31'b0, instr_valid}, 32'd0);
        end
        tk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("late_valid", {31'b0, instr_valid}, 32'd1);
        chk("late_instr", Instr, 32'h1234_5678);
        chk("late_err", {31'b0, fetch_err}, 32'd0);

        // Memory never answers: fault after TIMEOUT request cycles, held until reset
        tk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            tk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            chk("to_err_low", {31'b0, fetch_err}, 32'd0);
            chk("to_req_high", {31'b0, imem_req}, 32'd1);
        end
        for (int i = 0; i < 4; i++) begin
            tk(1'b0, 1'b1, 32'hFFFF_0000, 1'b1, 1'b0, 32'h0);
            @(negedge clk);
            chk("fault_err", {31'b0, fetch_err}, 32'd1);
            chk("fault_req", {31'b0, imem_req}, 32'd0);
            chk("fault_valid", {31'b0, instr_valid}, 32'd0);
        end
        tk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("rst_clears_err", {31'b0, fetch_err}, 32'd0);
        tk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("restart_req", {31'b0, imem_req}, 32'd1);
        chk("restart_addr", imem_addr, RESET_PC);

        // PC wrap from 0xFFFF_FFFC, branch target low bits dropped
        tk(1'b0, 1'b1, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0);
        tk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF);
        tk(1'b0, 1'b1, 32'h600D_600D, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        tk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        chk("top_pcplus4", PCPlus4, 32'h0);
        chk("top_pcplus8", PCPlus8, 32'h4);
        tk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk("wrap_addr", imem_addr, 32'h0);

        // Randomized run with random resets
        ack_pct = 50;
        for (int c = 0; c < 4000; c++) begin
            bit r;
            if (c % 50 == 0) begin
                case ($urandom_range(0, 3))
                    0:       ack_pct = 0;
                    1:       ack_pct = 15;
                    2:       ack_pct = 50;
                    default: ack_pct = 100;
                endcase
            end
            r = ($urandom_range(0, 199) == 0) || (m_fault && $urandom_range(0, 7) == 0);
            tk(r, ($urandom_range(0, 99) < ack_pct), $urandom, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 2) == 0), $urandom);
        end

        tk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 15, is the maximum number of cycles to wait for imem_ack before fault.
REQ-003 Port clk, input, 1, is the single clock; all state updates occur on its rising edge.
REQ-004 Port rst, input, 1, is the asynchronous active-high reset.
REQ-005 Port imem_req, output, 1, is the instruction-memory read request.
REQ-006 Port imem_addr, output, 32, is the read address and equals PC while imem_req is high.
REQ-007 Port imem_ack, input, 1, signals that imem_rdata is valid in the cycle it is sampled.
REQ-008 Port imem_rdata, input, 32, is the instruction word.
REQ-009 Port Instr, output, 32, is the held instruction register (IR).
REQ-010 Ports Cond[3:0], Op[1:0], Funct[5:0] and Rd[3:0] are outputs taken from IR[31:28], IR[27:26], IR[25:20] and IR[15:12].
REQ-011 Port instr_valid, output, 1, is high while IR holds an instruction not yet consumed.
REQ-012 Port instr_ack, input, 1, is the consumer accept; an instruction transfers when instr_valid and instr_ack are both high.
REQ-013 Port PCSrc, input, 1, is the branch-taken flag, sampled only on a transfer.
REQ-014 Port BranchTarget, input, 32, is the next PC when PCSrc=1, sampled only on a transfer.
REQ-015 Ports PCPlus4 and PCPlus8, outputs, 32, are the PC of the instruction in IR plus 4 and plus 8.
REQ-016 Port fetch_err, output, 1, is a sticky fault flag for memory timeout.

Function
REQ-017 The FSM SHALL have states FETCH, WAIT, ISSUE and FAULT.
REQ-018 In FETCH, imem_req SHALL be 1, and the FSM SHALL go to ISSUE if imem_ack=1 in that cycle, else to WAIT.
REQ-019 In WAIT, imem_req SHALL stay 1 with imem_addr stable, and the FSM SHALL go to ISSUE on imem_ack=1.
REQ-020 On the cycle imem_ack is sampled, IR SHALL load imem_rdata and the fetched PC SHALL be recorded for PCPlus4 and PCPlus8.
REQ-021 In ISSUE, instr_valid SHALL be 1, imem_req SHALL be 0, and IR SHALL be held stable until the transfer.
REQ-022 On a transfer, PC SHALL load BranchTarget if PCSrc=1, else PC+4 (modulo 2^32), and the FSM SHALL go to FETCH.
REQ-023 BranchTarget[1:0] SHALL be forced to 2'b00 when loaded into PC.
REQ-024 A wait counter SHALL clear on entry to FETCH and increment each cycle in FETCH or WAIT without imem_ack.
REQ-025 When the wait counter reaches TIMEOUT without an ack, the FSM SHALL go to FAULT.
REQ-026 In FAULT, imem_req=0, instr_valid=0 and fetch_err=1 SHALL hold until reset.
REQ-027 An imem_ack arriving while in ISSUE or FAULT SHALL be ignored.
REQ-028 Minimum latency from FETCH entry to instr_valid SHALL be 1 cycle (ack in the FETCH cycle), giving peak throughput of one instruction per 2 cycles.
REQ-029 PC increment from 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000 with no error.

Reset
REQ-030 On rst assertion, the FSM SHALL enter FETCH immediately, with PC=RESET_PC, IR=0, instr_valid=0, fetch_err=0 and wait counter=0.
REQ-031 On rst assertion, imem_req SHALL be 1 and imem_addr=RESET_PC from the first clock edge after deassertion.
REQ-032 A reset asserted mid-WAIT or mid-ISSUE SHALL abandon the pending fetch or instruction with no transfer.

Verification
REQ-033 Reset, then imem_ack=1 on the first FETCH cycle with rdata=32'hE080_2003 -> next cycle instr_valid=1, Cond=4'hE, Op=2'b00, Funct=6'h08, Rd=4'h2, PCPlus8=32'h8.
REQ-034 Transfer with PCSrc=0 at PC=0x10 -> next imem_addr=0x14; transfer with PCSrc=1 and BranchTarget=0x203 -> next imem_addr=0x200.
REQ-035 instr_ack held low for 5 cycles in ISSUE -> Instr stable, imem_req=0, and a spurious imem_ack is ignored.
REQ-036 imem_ack delayed 3 cycles -> imem_addr stable during WAIT, instr_valid rises the cycle after the ack, fetch_err=0.
REQ-037 imem_ack never asserted -> fetch_err=1 after TIMEOUT cycles and held; rst clears it and fetching restarts at RESET_PC.
REQ-038 PC=32'hFFFF_FFFC with a PCSrc=0 transfer -> next imem_addr=32'h0000_0000.
